uart_tx_fifo: RTL and testbench

Buffered, oversampled UART transmitter. It is the transmit-side counterpart to the UART receiver that runs on the prescaled oversampling clock. It accepts parallel bytes from the system side through a small FIFO and serialises them as start, data (LSB first), optional parity and stop bits. Each bit is held for `Prescale` clock cycles, so a link built from this block and the receiver can share one clock and one prescale setting.

---
 rtl/uart_tx_fifo.sv | 158 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter: small input FIFO feeding a prescaled serialiser
module uart_tx_fifo #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  output logic                      Ready,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic                      TX_OUT,
  output logic                      busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [AW:0]               CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]               CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]             PTR_ONE  = AW'(1);
  localparam logic [BW-1:0]             BIT_LAST = BW'(DATA_WIDTH-1);
  localparam logic [BW-1:0]             BIT_ONE  = BW'(1);
  localparam logic [PRESCALE_WIDTH-1:0] PS_MIN   = PRESCALE_WIDTH'(4);
  localparam logic [PRESCALE_WIDTH-1:0] PS_ONE   = PRESCALE_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [AW:0]               count_q;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic [PRESCALE_WIDTH-1:0] ps_q, ps_d, cyc_q, cyc_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic                      par_en_q, par_en_d, par_bit_q, par_bit_d;
  logic                      wr_en, pop, bit_end, fifo_nonempty;
  logic [DATA_WIDTH-1:0]     head;

  assign Ready         = (count_q != CNT_FULL);
  assign wr_en         = Data_Valid && Ready;
  assign fifo_nonempty = (count_q != '0);
  assign head          = mem_q[rd_ptr_q];
  assign bit_end       = (cyc_q == ps_q - PS_ONE);
  assign busy          = (state_q != IDLE);

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= P_DATA;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (wr_en && !pop)      count_q <= count_q + CNT_ONE;
      else if (!wr_en && pop) count_q <= count_q - CNT_ONE;
    end
  end

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    ps_d      = ps_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        cyc_d = cyc_q + PS_ONE;
        if (bit_end) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        cyc_d = cyc_q + PS_ONE;
        if (bit_end) begin
          cyc_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BIT_ONE;
          if (bit_q == BIT_LAST) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        cyc_d = cyc_q + PS_ONE;
        if (bit_end) begin
          cyc_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        cyc_d = cyc_q + PS_ONE;
        if (bit_end) begin
          cyc_d = '0;
          if (fifo_nonempty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Frame parameters are sampled only here, so mid-frame input changes wait for the next frame.
    if (pop) begin
      shift_d   = head;
      ps_d      = (Prescale < PS_MIN) ? PS_MIN : Prescale;
      par_en_d  = PAR_EN;
      par_bit_d = (^head) ^ PAR_TYP;
      cyc_d     = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      ps_q      <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      ps_q      <= ps_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

  always_comb begin
    TX_OUT = 1'b1;
    case (state_q)
      START:   TX_OUT = 1'b0;
      DATA:    TX_OUT = shift_q[0];
      PARITY:  TX_OUT = par_bit_q;
      default: TX_OUT = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
  logic       CLK = 1'b0, RST = 1'b0, Data_Valid = 1'b0, PAR_EN = 1'b0, PAR_TYP = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic [5:0] Prescale = 6'd8;
  logic       Ready, TX_OUT, busy;
  int         compared = 0, mismatched = 0;

  typedef struct { bit dv; bit [7:0] d; int p; bit pe; bit pt; } stim_t;
  stim_t      stim[$];
  bit [2:0]   got_s[$], exp_s[$];   // {Ready, busy, TX_OUT} sampled after each edge

  uart_tx_fifo #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid), .Ready(Ready),
    .Prescale(Prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int frame_bits(input bit [7:0] d, input bit pe, input bit pt, output bit b[11]);
    int ones = 0;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b[i+1] = d[i];
      ones += int'(d[i]);
    end
    b[9]  = pe ? (((ones % 2) == 1) ^ pt) : 1'b1;
    b[10] = 1'b1;
    return pe ? 11 : 10;
  endfunction

  task automatic add_stim(input int n, input bit dv, input bit [7:0] d, input int p, input bit pe, input bit pt);
    stim_t s;
    s.dv = dv; s.d = d; s.p = p; s.pe = pe; s.pt = pt;
    for (int i = 0; i < n; i++) stim.push_back(s);
  endtask

  // Drives stim cycle by cycle from a negedge; the reference model is a byte queue plus
  // the time the line becomes free, with each frame expanded from its bit list.
  task automatic run(input int n);
    bit [7:0] q[$];
    int next_free = 0, fstart = -1, flen = 0, fp = 4, pre;
    bit fb[11];
    bit in_frame;
    stim_t s;
    got_s.delete();
    exp_s.delete();
    for (int t = 0; t < n; t++) begin
      if (t < stim.size()) s = stim[t];
      else begin
        s = stim[stim.size()-1];
        s.dv = 1'b0;
      end
      Data_Valid = s.dv; P_DATA = s.d; Prescale = 6'(s.p); PAR_EN = s.pe; PAR_TYP = s.pt;
      pre = q.size();
      if (pre != 0 && t >= next_free) begin
        fp        = (s.p < 4) ? 4 : s.p;
        flen      = fp * frame_bits(q.pop_front(), s.pe, s.pt, fb);
        fstart    = t;
        next_free = t + flen;
      end
      if (s.dv && pre != 4) q.push_back(s.d);
      in_frame = (fstart >= 0) && (t < fstart + flen);
      exp_s.push_back({q.size() != 4, in_frame, in_frame ? fb[(t - fstart) / fp] : 1'b1});
      @(negedge CLK);
      got_s.push_back({Ready, busy, TX_OUT});
    end
    Data_Valid = 1'b0;
  endtask

  function automatic int trace_diff(output int first);
    int n = 0;
    first = 0;
    for (int i = 0; i < got_s.size(); i++)
      if (got_s[i] !== exp_s[i]) begin
        if (n == 0) first = i;
        n++;
      end
    return n;
  endfunction

  function automatic int busy_cycles(output int first);
    int n = 0;
    first = -1;
    for (int i = 0; i < got_s.size(); i++)
      if (got_s[i][1]) begin
        if (first < 0) first = i;
        n++;
      end
    return n;
  endfunction

  task automatic test_reset();
    #1 RST = 1'b1;
    #2;
    compared += 3;
    if (TX_OUT !== 1'b1) begin mismatched++; $display("FAIL reset_tx: got %b want 1", TX_OUT); end
    if (busy !== 1'b0)   begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (Ready !== 1'b1)  begin mismatched++; $display("FAIL reset_ready: got %b want 1", Ready); end
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b0;
    @(negedge CLK);
    compared += 1;
    if ({Ready, busy, TX_OUT} !== 3'b101) begin
      mismatched++; $display("FAIL post_reset_idle: got %b want 101", {Ready, busy, TX_OUT});
    end
  endtask

  task automatic test_single_even();
    int nd, fi, nb, fb0;
    bit [10:0] seq;
    stim.delete();
    add_stim(1, 1'b1, 8'hA5, 8, 1'b1, 1'b0);
    run(95);
    nd = trace_diff(fi); compared++;
    if (nd !== 0) begin mismatched++; $display("FAIL single_trace: %0d samples differ, first %0d got %b want %b", nd, fi, got_s[fi], exp_s[fi]); end
    for (int i = 0; i < 11; i++) seq[i] = got_s[1 + 8*i + 4][0];
    compared++;
    if (seq !== 11'h54A) begin mismatched++; $display("FAIL single_bits: got %b want %b", seq, 11'h54A); end
    nb = busy_cycles(fb0); compared += 2;
    if (nb !== 88) begin mismatched++; $display("FAIL single_busy_len: got %0d want 88", nb); end
    if (fb0 !== 1) begin mismatched++; $display("FAIL single_latency: busy first at %0d want 1", fb0); end
  endtask

  task automatic test_odd16();
    int nd, fi, nb, fb0;
    stim.delete();
    add_stim(1, 1'b1, 8'h01, 16, 1'b1, 1'b1);
    run(190);
    nd = trace_diff(fi); compared++;
    if (nd !== 0) begin mismatched++; $display("FAIL odd16_trace: %0d samples differ, first %0d got %b want %b", nd, fi, got_s[fi], exp_s[fi]); end
    compared++;
    if (got_s[1 + 16*9 + 8][0] !== 1'b0) begin mismatched++; $display("FAIL odd16_parity: got %b want 0", got_s[153][0]); end
    nb = busy_cycles(fb0); compared++;
    if (nb !== 176) begin mismatched++; $display("FAIL odd16_len: got %0d want 176", nb); end
  endtask

  task automatic test_nopar32();
    int nd, fi, nb, fb0;
    stim.delete();
    add_stim(1, 1'b1, 8'hFF, 32, 1'b0, 1'b0);
    run(330);
    nd = trace_diff(fi); compared++;
    if (nd !== 0) begin mismatched++; $display("FAIL nopar32_trace: %0d samples differ, first %0d got %b want %b", nd, fi, got_s[fi], exp_s[fi]); end
    nb = busy_cycles(fb0); compared++;
    if (nb !== 320) begin mismatched++; $display("FAIL nopar32_len: got %0d want 320", nb); end
  endtask

  task automatic test_back_to_back();
    int nd, fi, nb, fb0;
    stim.delete();
    for (int i = 0; i < 6; i++) add_stim(1, 1'b1, 8'(8'h10 + i), 8, 1'b0, 1'b0);
    run(420);
    nd = trace_diff(fi); compared++;
    if (nd !== 0) begin mismatched++; $display("FAIL b2b_trace: %0d samples differ, first %0d got %b want %b", nd, fi, got_s[fi], exp_s[fi]); end
    nb = busy_cycles(fb0); compared += 2;
    if (nb !== 400 || got_s[401][1] !== 1'b0) begin mismatched++; $display("FAIL b2b_busy: got %0d cycles want 400 continuous", nb); end
    if (got_s[4][2] !== 1'b0) begin mismatched++; $display("FAIL b2b_ready_full: got %b want 0", got_s[4][2]); end
    compared++;
    if (got_s[81][2] !== 1'b1) begin mismatched++; $display("FAIL b2b_ready_back: got %b want 1", got_s[81][2]); end
  endtask

  task automatic test_latching();
    int nd, fi, nb, fb0;
    bit pt;
    pt = 1'($urandom_range(0, 1));
    stim.delete();
    add_stim(1, 1'b1, 8'($urandom), 8, 1'b1, pt);
    add_stim(1, 1'b1, 8'($urandom), 8, 1'b1, pt);
    add_stim(28, 1'b0, 8'h00, 8, 1'b1, pt);
    add_stim(1, 1'b0, 8'h00, 16, 1'b0, ~pt);
    run(270);
    nd = trace_diff(fi); compared++;
    if (nd !== 0) begin mismatched++; $display("FAIL latch_trace: %0d samples differ, first %0d got %b want %b", nd, fi, got_s[fi], exp_s[fi]); end
    nb = busy_cycles(fb0); compared++;
    if (nb !== 248) begin mismatched++; $display("FAIL latch_len: got %0d want 248", nb); end
  endtask

  task automatic test_random();
    int nd, fi, p;
    bit pe, pt, burst;
    for (int r = 0; r < 3; r++) begin
      stim.delete();
      for (int seg = 0; seg < 8; seg++) begin
        p     = $urandom_range(0, 17);
        pe    = 1'($urandom_range(0, 1));
        pt    = 1'($urandom_range(0, 1));
        burst = ($urandom_range(0, 3) == 0);
        for (int c = 0; c < 150; c++)
          add_stim(1, ($urandom_range(0, burst ? 1 : 24) == 0), 8'($urandom), p, pe, pt);
      end
      run(stim.size() + 1000);
      nd = trace_diff(fi); compared++;
      if (nd !== 0) begin mismatched++; $display("FAIL random_trace[%0d]: %0d samples differ, first %0d got %b want %b", r, nd, fi, got_s[fi], exp_s[fi]); end
    end
  endtask

  task automatic test_reset_mid();
    int nd, fi, bad = 0;
    Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    for (int i = 0; i < 5; i++) begin
      Data_Valid = 1'b1;
      P_DATA = 8'($urandom);
      @(negedge CLK);
    end
    Data_Valid = 1'b0;
    repeat (20) @(negedge CLK);
    compared++;
    if ({Ready, busy} !== 2'b01) begin mismatched++; $display("FAIL rstmid_pre: got ready/busy %b want 01", {Ready, busy}); end
    #2 RST = 1'b1;
    #1;
    compared += 3;
    if (TX_OUT !== 1'b1) begin mismatched++; $display("FAIL rstmid_tx: got %b want 1", TX_OUT); end
    if (busy !== 1'b0)   begin mismatched++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    if (Ready !== 1'b1)  begin mismatched++; $display("FAIL rstmid_ready: got %b want 1", Ready); end
    @(negedge CLK);
    @(negedge CLK) RST = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (busy !== 1'b0 || TX_OUT !== 1'b1) bad++;
    end
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL rstmid_quiet: %0d active cycles want 0", bad); end
    stim.delete();
    add_stim(1, 1'b1, 8'($urandom), 8, 1'b1, 1'b1);
    run(100);
    nd = trace_diff(fi); compared++;
    if (nd !== 0) begin mismatched++; $display("FAIL rstmid_after: %0d samples differ, first %0d got %b want %b", nd, fi, got_s[fi], exp_s[fi]); end
  endtask

  initial begin
    test_reset();
    test_single_even();
    test_odd16();
    test_nopar32();
    test_back_to_back();
    test_latching();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
